// File: rtl/i2c_cfg_master_if.sv
// Control/status bundle between the start/reset logic and i2c_cfg_master.
// The controller uses the master modport; the I2C engine uses the slave modport.
interface i2c_cfg_master_if #(
  parameter int unsigned N_WORDS = 10
);
  logic                   i_start;
  logic [16*N_WORDS-1:0]  i_table;
  logic                   o_busy;
  logic                   o_finished;
  logic                   o_error;
  logic [7:0]             o_err_idx;

  modport master (
    output i_start, i_table,
    input  o_busy, o_finished, o_error, o_err_idx
  );

  modport slave (
    input  i_start, i_table,
    output o_busy, o_finished, o_error, o_err_idx
  );
endinterface

// File: rtl/i2c_cfg_master.sv
// Write-only I2C master: after i_start, sends each 16-bit table word to DEV_ADDR as a
// 3-byte transaction, retrying NACKed words up to MAX_RETRY times, then reports done/error.
module i2c_cfg_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned N_WORDS   = 10,
  parameter logic [6:0]  DEV_ADDR  = 7'h1A,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned GAP_TICKS = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  i2c_cfg_master_if.slave        io_ctrl,
  output logic                   o_sclk,
  inout  wire                    io_sdat
);

  typedef enum logic [2:0] {StIdle, StStart, StBits, StAck, StStop, StGap} state_e;

  state_e      r_state, w_state_nxt;
  logic [15:0] r_tick_cnt;
  logic [1:0]  r_q, w_q_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [1:0]  r_byte, w_byte_nxt;
  logic [7:0]  r_idx, w_idx_nxt;
  logic [3:0]  r_retry, w_retry_nxt;
  logic [7:0]  r_gap, w_gap_nxt;
  logic        r_nack, w_nack_nxt;
  logic        r_finished, w_finished_nxt;
  logic        r_error, w_error_nxt;
  logic [7:0]  r_err_idx, w_err_idx_nxt;
  logic        r_scl, r_sda_low;
  logic        w_scl_act, w_sda_low_act;
  logic [1:0]  r_sda_sync;
  logic        w_busy, w_tick;
  logic [15:0] w_word;
  logic [7:0]  w_byte_val;

  assign w_busy = (r_state != StIdle);
  assign w_tick = w_busy && (r_tick_cnt == 16'(CLK_DIV - 1));
  assign w_word = io_ctrl.i_table[{r_idx, 4'b0000} +: 16];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
      r_sda_sync <= 2'b11;
    end else begin
      r_tick_cnt <= (!w_busy || w_tick) ? 16'd0 : r_tick_cnt + 16'd1;
      r_sda_sync <= {r_sda_sync[0], io_sdat};
    end
  end

  // State register; the pin levels only move on tick cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_q        <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_idx      <= '0;
      r_retry    <= '0;
      r_gap      <= '0;
      r_nack     <= 1'b0;
      r_finished <= 1'b0;
      r_error    <= 1'b0;
      r_err_idx  <= '0;
      r_scl      <= 1'b1;
      r_sda_low  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_q        <= w_q_nxt;
      r_bit      <= w_bit_nxt;
      r_byte     <= w_byte_nxt;
      r_idx      <= w_idx_nxt;
      r_retry    <= w_retry_nxt;
      r_gap      <= w_gap_nxt;
      r_nack     <= w_nack_nxt;
      r_finished <= w_finished_nxt;
      r_error    <= w_error_nxt;
      r_err_idx  <= w_err_idx_nxt;
      if (w_tick) begin
        r_scl     <= w_scl_act;
        r_sda_low <= w_sda_low_act;
      end
    end
  end

  // Next state; r_q is the sub-step whose pin action the coming tick performs.
  always_comb begin
    w_state_nxt    = r_state;
    w_q_nxt        = r_q;
    w_bit_nxt      = r_bit;
    w_byte_nxt     = r_byte;
    w_idx_nxt      = r_idx;
    w_retry_nxt    = r_retry;
    w_gap_nxt      = r_gap;
    w_nack_nxt     = r_nack;
    w_finished_nxt = r_finished;
    w_error_nxt    = r_error;
    w_err_idx_nxt  = r_err_idx;
    if (r_state == StIdle) begin
      if (io_ctrl.i_start) begin
        w_state_nxt    = StStart;
        w_q_nxt        = 2'd0;
        w_idx_nxt      = 8'd0;
        w_retry_nxt    = 4'd0;
        w_finished_nxt = 1'b0;
        w_error_nxt    = 1'b0;
        w_err_idx_nxt  = 8'd0;
      end
    end else if (w_tick) begin
      w_q_nxt = r_q + 2'd1;
      case (r_state)
        StStart: begin
          if (r_q == 2'd1) begin
            w_state_nxt = StBits;
            w_q_nxt     = 2'd0;
            w_bit_nxt   = 3'd7;
            w_byte_nxt  = 2'd0;
            w_nack_nxt  = 1'b0;
          end
        end
        StBits: begin
          if (r_q == 2'd3) begin
            if (r_bit == 3'd0) w_state_nxt = StAck;
            else               w_bit_nxt   = r_bit - 3'd1;
          end
        end
        StAck: begin
          if (r_q == 2'd3) begin
            if (r_sda_sync[1]) begin
              w_state_nxt = StStop;
              w_nack_nxt  = 1'b1;
            end else if (r_byte == 2'd2) begin
              w_state_nxt = StStop;
            end else begin
              w_state_nxt = StBits;
              w_byte_nxt  = r_byte + 2'd1;
              w_bit_nxt   = 3'd7;
            end
          end
        end
        StStop: begin
          if (r_q == 2'd2) begin
            w_q_nxt     = 2'd0;
            w_gap_nxt   = 8'd0;
            w_state_nxt = StGap;
            if (r_nack) begin
              if (r_retry == 4'(MAX_RETRY)) begin
                w_state_nxt   = StIdle;
                w_error_nxt   = 1'b1;
                w_err_idx_nxt = r_idx;
              end else begin
                w_retry_nxt = r_retry + 4'd1;
              end
            end else if (r_idx == 8'(N_WORDS - 1)) begin
              w_state_nxt    = StIdle;
              w_finished_nxt = 1'b1;
            end else begin
              w_idx_nxt   = r_idx + 8'd1;
              w_retry_nxt = 4'd0;
            end
          end
        end
        StGap: begin
          w_q_nxt = 2'd0;
          if (r_gap == 8'(GAP_TICKS - 1)) w_state_nxt = StStart;
          else                             w_gap_nxt   = r_gap + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_byte)
      2'd0:    w_byte_val = {DEV_ADDR, 1'b0};
      2'd1:    w_byte_val = w_word[15:8];
      default: w_byte_val = w_word[7:0];
    endcase
  end

  // Pin action performed by the next tick in the current state/sub-step.
  always_comb begin
    w_scl_act     = 1'b1;
    w_sda_low_act = 1'b0;
    case (r_state)
      StStart: begin
        w_scl_act     = (r_q == 2'd0);
        w_sda_low_act = 1'b1;
      end
      StBits: begin
        w_scl_act     = r_q[1];
        w_sda_low_act = !w_byte_val[r_bit];
      end
      StAck:  w_scl_act = r_q[1];
      StStop: begin
        w_scl_act     = (r_q != 2'd0);
        w_sda_low_act = (r_q != 2'd2);
      end
      default: ;
    endcase
  end

  assign o_sclk             = r_scl;
  assign io_sdat            = r_sda_low ? 1'b0 : 1'bz;
  assign io_ctrl.o_busy     = w_busy;
  assign io_ctrl.o_finished = r_finished;
  assign io_ctrl.o_error    = r_error;
  assign io_ctrl.o_err_idx  = r_err_idx;

endmodule

// File: doc/i2c_cfg_master.md
Name: i2c_cfg_master

Overview:
Parametrised I2C write-only configuration master that programs a table of N_WORDS 16-bit register words into one 7-bit-addressed device after power-up, e.g. the audio codec or video decoder. Adds an SCL rate divider, NACK retry with a bounded count, error reporting with the failing word index, and open-drain SDA. Sits between the top-level start/reset logic and the board I2C pins. Downstream datapaths wait for o_finished before starting.

Parameters:
CLK_DIV, 4, i_clk cycles per quarter SCL period (tick); legal range 2..65535.
N_WORDS, 10, number of 16-bit words in the table; legal range 1..256.
DEV_ADDR, 7'h1A, 7-bit device address; sent on the wire as {DEV_ADDR,1'b0}.
MAX_RETRY, 3, extra attempts per word after a NACK; legal range 0..15.
GAP_TICKS, 4, idle ticks between a STOP and the next START; legal range 1..255.

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous reset, active-low
i_start  in  1  single-cycle request that starts a table run
i_table  in  16*N_WORDS  word k = i_table[16k+15:16k]; word 0 is sent first; must be held stable while o_busy=1
o_sclk  out  1  SCL, push-pull (no clock stretching)
io_sdat  inout  1  SDA, open-drain: the block drives 0 or releases to 'z; it never drives 1
o_busy  out  1  high from the cycle after i_start is accepted until the run ends
o_finished  out  1  level; high after every word is ACKed; cleared by the next accepted i_start
o_error  out  1  level; high after retries for a word are exhausted; cleared by the next accepted i_start
o_err_idx  out  8  index of the word that failed; valid while o_error=1

Behaviour:
- Reset (async assert, sync release) puts the block in IDLE: o_sclk=1, io_sdat='z, o_busy=0, o_finished=0, o_error=0, o_err_idx=0. The tick counter and retry counter clear to 0. Reset mid-transfer aborts at once with no STOP sent.
- Tick: a free-running counter counts 0..CLK_DIV-1 while o_busy=1 and emits a 1-cycle tick at CLK_DIV-1. All SCL/SDA changes happen on tick cycles only.
- An i_start in IDLE is accepted: o_finished and o_error clear, word index=0, retry=0, o_busy=1 next cycle. i_start is ignored while o_busy=1.
- FSM: IDLE -> START -> BITS -> ACK -> (BITS | STOP) -> GAP -> START ... -> IDLE.
- START, 2 ticks: SDA low with SCL high, then SCL low.
- BITS: 8 bits MSB first, 4 ticks per bit: q0 SCL=0 and set SDA; q1 SCL=0; q2 SCL=1; q3 SCL=1.
- Each transaction is 3 bytes: {DEV_ADDR,0}, word[15:8], word[7:0].
- ACK, 4 ticks: SDA released; io_sdat is sampled on the q3 tick. A 0 is ACK. After ACK on byte 0 or 1, go to BITS for the next byte. After ACK on byte 2, the word is done.
- A 1 at the ACK sample is NACK: go to STOP at once, skipping the remaining bytes.
- STOP, 3 ticks: SCL=0 with SDA=0; SCL=1; SDA released.
- After STOP:
  - Word ACKed: increment the index and reset retry.
  - NACK with retry<MAX_RETRY: increment retry and resend the same word.
  - NACK with retry=MAX_RETRY: o_error=1, o_err_idx=index, o_busy=0, return to IDLE; remaining words are skipped.
  - Last word (index N_WORDS-1) ACKed: o_finished=1, o_busy=0, IDLE. GAP is skipped after the final STOP.
- GAP: GAP_TICKS ticks with SCL=1 and SDA released.
- Clean transaction length: 2+27*4+3 = 113 ticks. Clean run length: N_WORDS*113 + (N_WORDS-1)*GAP_TICKS ticks, plus 1 clock of start latency.
- Bus invariant: SDA changes only while SCL=0, except inside START and STOP.

Test Plan:
- Reset then idle: hold i_rst_n=0, release, no i_start for 1000 cycles -> o_sclk=1, io_sdat='z, o_busy=0, o_finished=0, o_error=0.
- Clean run, CLK_DIV=4, N_WORDS=3, GAP_TICKS=4, table {16'h1201,16'h0C00,16'h0097}, slave model ACKs all:
  - bytes decoded on the wire: 34 00 97 / 34 0C 00 / 34 12 01, each framed by START/STOP;
  - o_finished rises (3*113+2*4)*4+1 = 1389 cycles after i_start; o_error=0.
- NACK then recover, MAX_RETRY=3: slave NACKs word 1's address twice, then ACKs -> word 1 appears 3 times on the wire; o_finished=1, o_error=0.
- Retry exhausted, MAX_RETRY=2: slave always NACKs word 2 -> word 2 attempted 3 times; o_error=1, o_err_idx=2, o_finished=0, o_busy=0; bus released (SCL=1, SDA='z).
- i_start while busy, then restart: pulse i_start mid-run -> ignored, with no extra transactions. After o_error, pulse i_start -> o_error clears the next cycle and a full run restarts from word 0.
- Reset mid-transfer: assert i_rst_n during byte 1 of word 0 -> o_sclk=1 and io_sdat='z in the same cycle, all flags 0; a later i_start restarts cleanly from word 0.
